// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external memory responder:
// FSM state encoding, memory region codes and channel indices.
package ext_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [1:0] REG_INSTR  = 2'd0;
   localparam logic [1:0] REG_WEIGHT = 2'd1;
   localparam logic [1:0] REG_FEAT   = 2'd2;

   localparam logic [1:0] CH_INSTR  = 2'd0;
   localparam logic [1:0] CH_WEIGHT = 2'd1;
   localparam logic [1:0] CH_FEAT   = 2'd2;

   // Round-robin pick: search starts at the channel after the last one served.
   function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
      logic [1:0] pick;
      unique case (last)
         CH_INSTR:  pick = pend[1] ? CH_WEIGHT : (pend[2] ? CH_FEAT : CH_INSTR);
         CH_WEIGHT: pick = pend[2] ? CH_FEAT : (pend[0] ? CH_INSTR : CH_WEIGHT);
         default:   pick = pend[0] ? CH_INSTR : (pend[1] ? CH_WEIGHT : CH_FEAT);
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/rd_req_slot.sv
// One-deep pending request slot for a single read channel, with a sticky
// overrun flag for requests that arrive while the slot is still occupied.
module rd_req_slot #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              clr,
   output logic              pending,
   output logic [ADDR_W-1:0] addr,
   output logic              overrun
);

   logic              pending_q, pending_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              overrun_q, overrun_d;

   // A request landing in the same cycle the slot is released is kept (set wins).
   always_comb begin
      pending_d = pending_q;
      addr_d    = addr_q;
      overrun_d = overrun_q;
      if (clr) begin
         pending_d = 1'b0;
      end
      if (rd_en) begin
         if (!pending_q || clr) begin
            pending_d = 1'b1;
            addr_d    = rd_addr;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         addr_q    <= addr_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign addr    = addr_q;
   assign overrun = overrun_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Serialises instruction/weight/feature read requests round-robin onto one
// external memory read channel and returns each word with a one-cycle strobe.
module ext_mem_responder
   import ext_mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int FEAT_W  = 128,
   parameter int WT_W    = 64,
   parameter int INSTR_W = 64,
   parameter int MEM_DW  = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_rd_en,
   input  logic [ADDR_W-1:0]   instr_fetch_addr,
   output logic [INSTR_W-1:0]  instr_port,
   output logic                instr_valid,
   input  logic                i_w_enable,
   input  logic [ADDR_W-1:0]   i_w_addr,
   output logic [WT_W-1:0]     i_w_bus_port,
   output logic                i_w_valid,
   input  logic                i_feature_rd_en,
   input  logic [ADDR_W-1:0]   i_feature_addr,
   output logic [FEAT_W-1:0]   i_data_bus_port,
   output logic                i_feature_valid,
   output logic                mem_req,
   output logic [ADDR_W+1:0]   mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [MEM_DW-1:0]   mem_rdata,
   output logic [2:0]          overrun,
   output logic                busy
);

   logic [2:0]        pend;
   logic [2:0]        clr;
   logic [ADDR_W-1:0] slot_addr_i, slot_addr_w, slot_addr_f;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        last_q, last_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W+1:0] mem_addr_q, mem_addr_d;
   logic [INSTR_W-1:0] instr_port_q, instr_port_d;
   logic [WT_W-1:0]   w_port_q, w_port_d;
   logic [FEAT_W-1:0] f_port_q, f_port_d;
   logic              instr_valid_q, instr_valid_d;
   logic              w_valid_q, w_valid_d;
   logic              f_valid_q, f_valid_d;

   logic [1:0]        pick;
   logic [ADDR_W-1:0] pick_addr;

   rd_req_slot #(.ADDR_W(ADDR_W)) u_slot_instr (
      .clk(clk), .rst(rst), .rd_en(instr_rd_en), .rd_addr(instr_fetch_addr),
      .clr(clr[CH_INSTR]), .pending(pend[CH_INSTR]), .addr(slot_addr_i),
      .overrun(overrun[CH_INSTR])
   );

   rd_req_slot #(.ADDR_W(ADDR_W)) u_slot_weight (
      .clk(clk), .rst(rst), .rd_en(i_w_enable), .rd_addr(i_w_addr),
      .clr(clr[CH_WEIGHT]), .pending(pend[CH_WEIGHT]), .addr(slot_addr_w),
      .overrun(overrun[CH_WEIGHT])
   );

   rd_req_slot #(.ADDR_W(ADDR_W)) u_slot_feat (
      .clk(clk), .rst(rst), .rd_en(i_feature_rd_en), .rd_addr(i_feature_addr),
      .clr(clr[CH_FEAT]), .pending(pend[CH_FEAT]), .addr(slot_addr_f),
      .overrun(overrun[CH_FEAT])
   );

   // A slot is released only in the response cycle of its own channel.
   always_comb begin
      clr = 3'b000;
      if (state_q == RESP) begin
         clr[sel_q] = 1'b1;
      end
   end

   always_comb begin
      pick = rr_pick(pend, last_q);
      unique case (pick)
         CH_INSTR:  pick_addr = slot_addr_i;
         CH_WEIGHT: pick_addr = slot_addr_w;
         default:   pick_addr = slot_addr_f;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_d        = last_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_port_d  = instr_port_q;
      w_port_d      = w_port_q;
      f_port_d      = f_port_q;
      instr_valid_d = 1'b0;
      w_valid_d     = 1'b0;
      f_valid_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|pend) begin
               sel_d      = pick;
               last_d     = pick;
               // Channel index doubles as the region code in the upper address bits.
               mem_addr_d = {pick, pick_addr};
               mem_req_d  = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               unique case (sel_q)
                  CH_INSTR: begin
                     instr_port_d  = mem_rdata[INSTR_W-1:0];
                     instr_valid_d = 1'b1;
                  end
                  CH_WEIGHT: begin
                     w_port_d  = mem_rdata[WT_W-1:0];
                     w_valid_d = 1'b1;
                  end
                  default: begin
                     f_port_d  = mem_rdata[FEAT_W-1:0];
                     f_valid_d = 1'b1;
                  end
               endcase
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The pointer resets to the feature channel so instr is searched first.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         sel_q         <= CH_INSTR;
         last_q        <= CH_FEAT;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_port_q  <= '0;
         w_port_q      <= '0;
         f_port_q      <= '0;
         instr_valid_q <= 1'b0;
         w_valid_q     <= 1'b0;
         f_valid_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         last_q        <= last_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_port_q  <= instr_port_d;
         w_port_q      <= w_port_d;
         f_port_q      <= f_port_d;
         instr_valid_q <= instr_valid_d;
         w_valid_q     <= w_valid_d;
         f_valid_q     <= f_valid_d;
      end
   end

   assign instr_port      = instr_port_q;
   assign instr_valid     = instr_valid_q;
   assign i_w_bus_port    = w_port_q;
   assign i_w_valid       = w_valid_q;
   assign i_data_bus_port = f_port_q;
   assign i_feature_valid = f_valid_q;
   assign mem_req         = mem_req_q;
   assign mem_addr        = mem_addr_q;
   assign busy            = (state_q != IDLE) || (|pend);

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: hand-computed responses, strobe
// timing, round-robin order, overrun, stalls and mid-transaction reset.
module tb_ext_mem_responder;

   logic          clk;
   logic          rst;
   logic          instr_rd_en;
   logic [15:0]   instr_fetch_addr;
   logic [63:0]   instr_port;
   logic          instr_valid;
   logic          i_w_enable;
   logic [15:0]   i_w_addr;
   logic [63:0]   i_w_bus_port;
   logic          i_w_valid;
   logic          i_feature_rd_en;
   logic [15:0]   i_feature_addr;
   logic [127:0]  i_data_bus_port;
   logic          i_feature_valid;
   logic          mem_req;
   logic [17:0]   mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [127:0]  mem_rdata;
   logic [2:0]    overrun;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;
   int hs_before;

   ext_mem_responder dut (
      .clk(clk), .rst(rst),
      .instr_rd_en(instr_rd_en), .instr_fetch_addr(instr_fetch_addr),
      .instr_port(instr_port), .instr_valid(instr_valid),
      .i_w_enable(i_w_enable), .i_w_addr(i_w_addr),
      .i_w_bus_port(i_w_bus_port), .i_w_valid(i_w_valid),
      .i_feature_rd_en(i_feature_rd_en), .i_feature_addr(i_feature_addr),
      .i_data_bus_port(i_data_bus_port), .i_feature_valid(i_feature_valid),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts accepted memory handshakes so the bench can tell how many transactions were issued.
   always @(posedge clk) begin
      if (mem_req && mem_gnt) hs_count <= hs_count + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Raises the requested rd_en pulses for exactly one cycle.
   task automatic applyStimulus(input logic ie, input logic [15:0] ia,
                                input logic we, input logic [15:0] wa,
                                input logic fe, input logic [15:0] fa);
      instr_rd_en      = ie;
      instr_fetch_addr = ia;
      i_w_enable       = we;
      i_w_addr         = wa;
      i_feature_rd_en  = fe;
      i_feature_addr   = fa;
      step();
      instr_rd_en      = 1'b0;
      i_w_enable       = 1'b0;
      i_feature_rd_en  = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      instr_rd_en = 1'b0; instr_fetch_addr = '0;
      i_w_enable = 1'b0; i_w_addr = '0;
      i_feature_rd_en = 1'b0; i_feature_addr = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step();
      step();
      checkOutput("rst_instr_port", 128'(instr_port), 128'h0);
      checkOutput("rst_valids", 128'({instr_valid, i_w_valid, i_feature_valid}), 128'h0);
      checkOutput("rst_mem_req", 128'(mem_req), 128'h0);
      checkOutput("rst_mem_addr", 128'(mem_addr), 128'h0);
      checkOutput("rst_overrun", 128'(overrun), 128'h0);
      checkOutput("rst_busy", 128'(busy), 128'h0);
      rst = 1'b1;
      step();

      $display("[TB] single instr read");
      mem_gnt = 1'b1;
      applyStimulus(1'b1, 16'h0005, 1'b0, 16'h0, 1'b0, 16'h0);
      checkOutput("t1_c1_busy", 128'(busy), 128'h1);
      checkOutput("t1_c1_req", 128'(mem_req), 128'h0);
      step();
      checkOutput("t1_c2_req", 128'(mem_req), 128'h1);
      checkOutput("t1_c2_addr", 128'(mem_addr), 128'h00005);
      step();
      checkOutput("t1_c3_valid", 128'(instr_valid), 128'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      step();
      mem_rvalid = 1'b0;
      checkOutput("t1_c4_valid", 128'(instr_valid), 128'h1);
      checkOutput("t1_c4_data", 128'(instr_port), 128'h0123456789ABCDEF);
      step();
      checkOutput("t1_c5_valid", 128'(instr_valid), 128'h0);
      checkOutput("t1_c5_busy", 128'(busy), 128'h0);
      checkOutput("t1_c5_hold", 128'(instr_port), 128'h0123456789ABCDEF);

      $display("[TB] three channels at once");
      doReset();
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 128'h11111111_11111111_AAAA0000_0000AAAA;
      applyStimulus(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1, 16'h0003);
      step();
      checkOutput("t2_instr_addr", 128'(mem_addr), 128'h00001);
      step();
      step();
      checkOutput("t2_instr_valid", 128'({instr_valid, i_w_valid, i_feature_valid}), 128'h4);
      checkOutput("t2_instr_data", 128'(instr_port), 128'hAAAA00000000AAAA);
      step();
      step();
      checkOutput("t2_weight_addr", 128'(mem_addr), 128'h10002);
      mem_rdata = 128'h22222222_22222222_BBBB1234_5678BBBB;
      step();
      step();
      checkOutput("t2_weight_valid", 128'({instr_valid, i_w_valid, i_feature_valid}), 128'h2);
      checkOutput("t2_weight_data", 128'(i_w_bus_port), 128'hBBBB12345678BBBB);
      step();
      step();
      checkOutput("t2_feat_addr", 128'(mem_addr), 128'h20003);
      mem_rdata = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      step();
      step();
      checkOutput("t2_feat_valid", 128'({instr_valid, i_w_valid, i_feature_valid}), 128'h1);
      checkOutput("t2_feat_data", i_data_bus_port, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      step();
      checkOutput("t2_idle_busy", 128'(busy), 128'h0);

      $display("[TB] weight overrun");
      mem_gnt = 1'b0;
      hs_before = hs_count;
      applyStimulus(1'b0, 16'h0, 1'b1, 16'h0007, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'h0, 1'b1, 16'h0008, 1'b0, 16'h0);
      checkOutput("t3_overrun", 128'(overrun), 128'h2);
      checkOutput("t3_addr", 128'(mem_addr), 128'h10007);
      mem_gnt = 1'b1;
      mem_rdata = 128'h0_00000000_77777777;
      step();
      step();
      checkOutput("t3_valid", 128'(i_w_valid), 128'h1);
      checkOutput("t3_data", 128'(i_w_bus_port), 128'h77777777);
      step();
      checkOutput("t3_busy", 128'(busy), 128'h0);
      step();
      checkOutput("t3_no_req", 128'(mem_req), 128'h0);
      checkOutput("t3_one_txn", 128'(hs_count - hs_before), 128'h1);

      $display("[TB] stalled grant and data");
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0);
      step();
      for (int k = 0; k < 5; k++) begin
         checkOutput("t4_hold_req", 128'(mem_req), 128'h1);
         checkOutput("t4_hold_addr", 128'(mem_addr), 128'h01234);
         if (k == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 128'hBAD0BAD0_BAD0BAD0;
         end else begin
            mem_rvalid = 1'b0;
         end
         step();
      end
      checkOutput("t4_c7_req", 128'(mem_req), 128'h1);
      checkOutput("t4_c7_valid", 128'(instr_valid), 128'h0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      checkOutput("t4_c8_req", 128'(mem_req), 128'h0);
      step();
      step();
      checkOutput("t4_c10_valid", 128'(instr_valid), 128'h0);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 128'h0_FEDCBA98_76543210;
      step();
      mem_rvalid = 1'b0;
      checkOutput("t4_c12_valid", 128'(instr_valid), 128'h1);
      checkOutput("t4_c12_data", 128'(instr_port), 128'hFEDCBA9876543210);

      $display("[TB] reset during WAIT");
      step();
      mem_gnt = 1'b1;
      applyStimulus(1'b1, 16'h0042, 1'b0, 16'h0, 1'b0, 16'h0);
      step();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 128'h0_55555555_55555555;
      step();
      mem_rvalid = 1'b0;
      checkOutput("t5_valid", 128'(instr_valid), 128'h0);
      checkOutput("t5_busy", 128'(busy), 128'h0);
      checkOutput("t5_req", 128'(mem_req), 128'h0);
      checkOutput("t5_addr", 128'(mem_addr), 128'h0);
      checkOutput("t5_overrun", 128'(overrun), 128'h0);
      checkOutput("t5_port", 128'(instr_port), 128'h0);

      $display("[TB] feature request in its own response cycle");
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 128'h10101010_10101010_10101010_10101010;
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0010);
      step();
      checkOutput("t6_addr1", 128'(mem_addr), 128'h20010);
      step();
      step();
      checkOutput("t6_valid1", 128'(i_feature_valid), 128'h1);
      checkOutput("t6_data1", i_data_bus_port, 128'h10101010_10101010_10101010_10101010);
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0011);
      checkOutput("t6_valid_drop", 128'(i_feature_valid), 128'h0);
      step();
      checkOutput("t6_addr2", 128'(mem_addr), 128'h20011);
      checkOutput("t6_overrun", 128'(overrun), 128'h0);
      mem_rdata = 128'h20202020_20202020_20202020_20202020;
      step();
      step();
      checkOutput("t6_valid2", 128'(i_feature_valid), 128'h1);
      checkOutput("t6_data2", i_data_bus_port, 128'h20202020_20202020_20202020_20202020);
      mem_rvalid = 1'b0;
      step();
      checkOutput("t6_busy", 128'(busy), 128'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
